nvdla_cmac_qch_pwr_ctrl: RTL
============================

// Module: nvdla_cmac_qch_pwr_ctrl
// PURPOSE
//  Q-channel power-policy controller upstream of the CMAC Q-channel block; drives qreqn and consumes qacceptn/qdeny.
//  Detects sustained CMAC idle, requests quiescence, and on accept sequences save -> isolate -> power-off.
//  On wake it sequences power-up -> restore pulse -> Q-channel exit. A denied request triggers a back-off.
// PARAMETERS
//  IDLE_CYCLES   16  consecutive idle cycles required before qreqn_o falls
//  PWRUP_CYCLES  8   cycles from power-switch on to the pr_restore pulse
//  BACKOFF       32  cycles after a deny completes before idle counting resumes
//  CNT_W         8   counter width; must hold max(IDLE_CYCLES,PWRUP_CYCLES,BACKOFF)
// PORTS
//  nvdla_core_clk   in   1  core clock
//  nvdla_core_rstn  in   1  asynchronous active-low reset
//  pwr_en_i         in   1  software enable for auto power-down
//  idle_i           in   1  CMAC idle: no csb req pending, op_en=0
//  wake_i           in   1  wake request, e.g. a csb request is pending
//  qacceptn_i       in   1  Q-channel accept, from the CMAC Q-channel block
//  qdeny_i          in   1  Q-channel deny, from the CMAC Q-channel block
//  qreqn_o          out  1  Q-channel request, active low
//  pr_save_o        out  1  one-cycle retention-save pulse
//  pr_restore_o     out  1  one-cycle retention-restore pulse
//  iso_en_o         out  1  output isolation enable
//  pwr_off_o        out  1  power-switch off request
//  state_o          out  3  current FSM state encoding
//  deny_cnt_o       out  8  saturating count of denied requests
//  proto_err_o      out  1  sticky flag: device Q-channel protocol violation
// BEHAVIOUR
//  Reset values: qreqn_o=1; pr_save_o, pr_restore_o, iso_en_o, pwr_off_o=0; state=RUN; deny_cnt_o=0; proto_err_o=0.
//  Reset is asynchronous and overrides all sequencing, including while in OFF.
//  All outputs are flops decoded from the next state, so they change on the same edge the state is entered.
//  RUN: idle counter increments while pwr_en_i & idle_i & !wake_i & qacceptn_i & !qdeny_i; otherwise it clears to 0.
//   When count==IDLE_CYCLES-1 and the condition still holds -> REQ, so qreqn_o falls on the 16th qualifying edge.
//  REQ: qreqn_o=0. qdeny_i=1 -> DENIED. qacceptn_i=0 & !qdeny_i -> SAVE.
//   wake_i cannot abort REQ, because qreqn may only rise when qacceptn==qdeny.
//  DENIED: qreqn_o=1 and deny_cnt_o increments (saturates at 255). Waits for qdeny_i=0, then -> BACKOFF.
//  BACKOFF: qreqn_o=1 and the idle counter is held at 0. After BACKOFF cycles -> RUN.
//  SAVE: pr_save_o=1 for exactly 1 cycle; iso_en_o=1 from this state on. -> OFF.
//  OFF: pwr_off_o=1, iso_en_o=1, minimum stay 1 cycle. wake_i | !pwr_en_i -> PWRUP.
//  PWRUP: pwr_off_o=0, iso_en_o=1. After PWRUP_CYCLES cycles -> RESTORE.
//  RESTORE: pr_restore_o=1 for exactly 1 cycle; iso_en_o=1. -> EXIT.
//  EXIT: qreqn_o=1 and iso_en_o=0. Waits for qacceptn_i=1, then -> RUN with the idle counter cleared.
//  qreqn_o=0 in REQ, SAVE, OFF, PWRUP and RESTORE. qreqn_o rises exactly 1 cycle after the pr_restore_o pulse.
//  Protocol checks: proto_err_o sets and stays set if any of these occur:
//   - qacceptn_i falls while qreqn_o=1;
//   - qdeny_i rises while qreqn_o=1;
//   - qacceptn_i rises while qreqn_o=0.
//  The FSM itself ignores these violations.
//  Simultaneous events:
//   - qdeny_i=1 and qacceptn_i=0 together in REQ is a violation: set proto_err_o and take DENIED.
//   - wake_i arriving on the same edge as SAVE entry is honoured after the 1-cycle minimum in OFF.
//   - pwr_en_i falling in RUN clears the idle counter; no request is issued.
// STRUCTURE
//  Package nvdla_cmac_pwr_pkg holds:
//   - typedef enum logic[2:0] {RUN,REQ,DENIED,BACKOFF,SAVE,OFF,PWRUP,RESTORE}, with RUN=0;
//   - localparam DENY_CNT_W=8.
//  Sub-module nvdla_cmac_pwr_cnt: a single loadable CNT_W up-counter with clear and terminal-count compare.
//   It is shared by idle, back-off and power-up timing; only one of these is active per state.
// TESTING
//  1 Reset asserted mid-run -> qreqn_o=1, all pulse/iso/pwr outputs 0, state_o=0, deny_cnt_o=0.
//  2 pwr_en=1, idle=1, qacceptn=1 for 16 cycles -> qreqn_o falls at edge 16.
//    Device drops qacceptn 3 cycles later -> pr_save_o 1-cycle pulse, then pwr_off_o=1 and iso_en_o=1.
//  3 From OFF, wake_i pulse -> pwr_off_o=0 next edge.
//    8 cycles later pr_restore_o 1-cycle pulse, next cycle qreqn_o=1 and iso_en_o=0.
//    qacceptn rises -> RUN.
//  4 In REQ, qdeny rises -> qreqn_o=1 next edge, deny_cnt_o=1.
//    qdeny falls -> qreqn_o stays 1 for 32 cycles, then a new 16-cycle idle count starts.
//  5 idle_i drops at idle cycle 10 -> no request is issued.
//    idle_i returns -> qreqn_o falls 16 qualifying cycles later.
//  6 qacceptn_i forced low while in RUN -> proto_err_o=1 and stays 1; state_o unchanged.
//    Async reset while in OFF -> pwr_off_o=0 and qreqn_o=1 immediately.

Source files
------------

// File: rtl/nvdla_cmac_pwr_pkg.sv
// Shared types and helpers for the CMAC Q-channel power-policy controller.
//  pwr_state_e : FSM state encoding, also exported on state_o (RUN = 0).
//  DENY_CNT_W  : width of the saturating deny counter.
//  sat_inc     : saturating increment used by the deny counter.
//  qreq_active : decodes the states in which qreqn is held low.
package nvdla_cmac_pwr_pkg;

  localparam int DENY_CNT_W = 8;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    REQ     = 3'd1,
    DENIED  = 3'd2,
    BACKOFF = 3'd3,
    SAVE    = 3'd4,
    OFF     = 3'd5,
    PWRUP   = 3'd6,
    RESTORE = 3'd7
  } pwr_state_e;

  function automatic logic [DENY_CNT_W-1:0] sat_inc(input logic [DENY_CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(DENY_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic qreq_active(input pwr_state_e s);
    case (s)
      REQ, SAVE, OFF, PWRUP, RESTORE: qreq_active = 1'b1;
      default:                        qreq_active = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nvdla_cmac_pwr_cnt.sv
// Loadable up-counter with clear and terminal-count compare, shared by the
// idle, back-off and power-up timers of the power-policy controller.
//  clk, rst_n : clock and asynchronous active-low reset
//  clr        : synchronous clear (highest priority after reset)
//  load       : load load_val
//  inc        : increment by one
//  tc_val     : terminal-count compare value
//  tc         : high while the count equals tc_val
module nvdla_cmac_pwr_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear, load, increment or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (inc) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == tc_val);

endmodule

// File: rtl/nvdla_cmac_qch_pwr_ctrl.sv
// Q-channel power-policy controller in front of the CMAC Q-channel block.
// Detects sustained idle, requests quiescence and, once accepted, sequences
// save -> isolate -> power-off; on wake it sequences power-up -> restore ->
// Q-channel exit. A denied request is followed by a back-off period.
//  nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//  pwr_en_i, idle_i, wake_i         : policy inputs
//  qacceptn_i, qdeny_i              : Q-channel device responses
//  qreqn_o                          : Q-channel request (active low)
//  pr_save_o / pr_restore_o         : one-cycle retention pulses
//  iso_en_o / pwr_off_o             : isolation and power-switch controls
//  state_o, deny_cnt_o, proto_err_o : status
// All outputs are flops loaded from the next-state decode.
module nvdla_cmac_qch_pwr_ctrl
  import nvdla_cmac_pwr_pkg::*;
#(
  parameter int IDLE_CYCLES  = 16,
  parameter int PWRUP_CYCLES = 8,
  parameter int BACKOFF      = 32,
  parameter int CNT_W        = 8
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  pwr_en_i,
  input  logic                  idle_i,
  input  logic                  wake_i,
  input  logic                  qacceptn_i,
  input  logic                  qdeny_i,
  output logic                  qreqn_o,
  output logic                  pr_save_o,
  output logic                  pr_restore_o,
  output logic                  iso_en_o,
  output logic                  pwr_off_o,
  output logic [2:0]            state_o,
  output logic [DENY_CNT_W-1:0] deny_cnt_o,
  output logic                  proto_err_o
);

  pwr_state_e             state_r, next_state_s;
  logic                   cnt_clr_s, cnt_inc_s, cnt_tc_s;
  logic [CNT_W-1:0]       tc_val_s;
  logic                   idle_ok_s, err_s;
  logic                   wake_pend_r, qacc_d_r, qdeny_d_r;
  logic                   qreqn_r, pr_save_r, pr_restore_r, iso_en_r, pwr_off_r, proto_err_r;
  logic [DENY_CNT_W-1:0]  deny_cnt_r;

  // Idle qualifier; requiring qacceptn_i=1 also makes RUN act as the
  // Q-channel exit wait after RESTORE (counter held clear until accept rises).
  assign idle_ok_s = pwr_en_i & idle_i & ~wake_i & qacceptn_i & ~qdeny_i;

  nvdla_cmac_pwr_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .clr      (cnt_clr_s),
    .load     (1'b0),
    .inc      (cnt_inc_s),
    .load_val ({CNT_W{1'b0}}),
    .tc_val   (tc_val_s),
    .tc       (cnt_tc_s)
  );

  // Next-state and shared-counter control.
  always_comb begin
    next_state_s = state_r;
    cnt_clr_s    = 1'b1;
    cnt_inc_s    = 1'b0;
    tc_val_s     = {CNT_W{1'b0}};
    case (state_r)
      RUN: begin
        tc_val_s = CNT_W'(IDLE_CYCLES - 1);
        if (idle_ok_s) begin
          if (cnt_tc_s) begin
            next_state_s = REQ;
          end else begin
            cnt_clr_s = 1'b0;
            cnt_inc_s = 1'b1;
          end
        end else begin
          next_state_s = RUN;
        end
      end
      REQ: begin
        // Deny wins over a simultaneous accept; wake cannot abort here.
        if (qdeny_i) begin
          next_state_s = DENIED;
        end else if (!qacceptn_i) begin
          next_state_s = SAVE;
        end else begin
          next_state_s = REQ;
        end
      end
      DENIED: begin
        if (!qdeny_i) begin
          next_state_s = nvdla_cmac_pwr_pkg::BACKOFF;
        end else begin
          next_state_s = DENIED;
        end
      end
      nvdla_cmac_pwr_pkg::BACKOFF: begin
        tc_val_s = CNT_W'(BACKOFF - 1);
        if (cnt_tc_s) begin
          next_state_s = RUN;
        end else begin
          cnt_clr_s = 1'b0;
          cnt_inc_s = 1'b1;
        end
      end
      SAVE: begin
        next_state_s = OFF;
      end
      OFF: begin
        if (wake_i || wake_pend_r || !pwr_en_i) begin
          next_state_s = PWRUP;
        end else begin
          next_state_s = OFF;
        end
      end
      PWRUP: begin
        tc_val_s = CNT_W'(PWRUP_CYCLES - 1);
        if (cnt_tc_s) begin
          next_state_s = RESTORE;
        end else begin
          cnt_clr_s = 1'b0;
          cnt_inc_s = 1'b1;
        end
      end
      RESTORE: begin
        next_state_s = RUN;
      end
      default: begin
        next_state_s = RUN;
      end
    endcase
  end

  // Device-side Q-channel protocol violations, judged against the qreqn level
  // currently driven and the previous sample of each response.
  assign err_s = (qreqn_r  &  qacc_d_r  & ~qacceptn_i) |
                 (qreqn_r  & ~qdeny_d_r &  qdeny_i)    |
                 (~qreqn_r & ~qacc_d_r  &  qacceptn_i) |
                 ((state_r == REQ) & qdeny_i & ~qacceptn_i);

  // State register and next-state decoded output flops.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_r      <= RUN;
      qreqn_r      <= 1'b1;
      pr_save_r    <= 1'b0;
      pr_restore_r <= 1'b0;
      iso_en_r     <= 1'b0;
      pwr_off_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      qreqn_r      <= ~qreq_active(next_state_s);
      pr_save_r    <= (next_state_s == SAVE);
      pr_restore_r <= (next_state_s == RESTORE);
      iso_en_r     <= (next_state_s == SAVE) || (next_state_s == OFF) ||
                      (next_state_s == PWRUP) || (next_state_s == RESTORE);
      pwr_off_r    <= (next_state_s == OFF);
    end
  end

  // A wake seen while heading into SAVE/OFF is remembered so it is honoured
  // once the minimum OFF stay has elapsed, even if it was only a pulse.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wake_pend_r <= 1'b0;
    end else if ((next_state_s == SAVE) || (next_state_s == OFF)) begin
      wake_pend_r <= wake_pend_r | wake_i;
    end else begin
      wake_pend_r <= 1'b0;
    end
  end

  // Deny counter (counts entries into DENIED) and sticky protocol error.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      deny_cnt_r  <= {DENY_CNT_W{1'b0}};
      proto_err_r <= 1'b0;
      qacc_d_r    <= 1'b1;
      qdeny_d_r   <= 1'b0;
    end else begin
      if ((next_state_s == DENIED) && (state_r != DENIED)) begin
        deny_cnt_r <= sat_inc(deny_cnt_r);
      end else begin
        deny_cnt_r <= deny_cnt_r;
      end
      proto_err_r <= proto_err_r | err_s;
      qacc_d_r    <= qacceptn_i;
      qdeny_d_r   <= qdeny_i;
    end
  end

  assign qreqn_o      = qreqn_r;
  assign pr_save_o    = pr_save_r;
  assign pr_restore_o = pr_restore_r;
  assign iso_en_o     = iso_en_r;
  assign pwr_off_o    = pwr_off_r;
  assign state_o      = state_r;
  assign deny_cnt_o   = deny_cnt_r;
  assign proto_err_o  = proto_err_r;

endmodule
